// File: rtl/conv_result_buffer_if.sv
// rtl/conv_result_buffer_if.sv - Z-write and result-stream bundle for conv_result_buffer
//
// Purpose: groups the convolution processor Z-write port, control strobes
// and the result readout stream into one bundle.
// Ports:
//   writeZ_i/memZaddr_i/dataZ_i : write strobe, address, data from the processor
//   done_i / clr_i              : end-of-convolution pulse, overflow flag clear
//   data_o/valid_o/ready_i/last_o/idx_o : result stream
//   busy_o/drained_o/ovf_o      : status
// Modports: slave = buffer side, master = processor/host side.

interface conv_result_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) ();
  logic                  writeZ_i;
  logic [ADDR_WIDTH-1:0] memZaddr_i;
  logic [DATA_WIDTH-1:0] dataZ_i;
  logic                  done_i;
  logic                  clr_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  last_o;
  logic [ADDR_WIDTH-1:0] idx_o;
  logic                  busy_o;
  logic                  drained_o;
  logic                  ovf_o;

  modport slave (
    input  writeZ_i, memZaddr_i, dataZ_i, done_i, clr_i, ready_i,
    output data_o, valid_o, last_o, idx_o, busy_o, drained_o, ovf_o
  );

  modport master (
    output writeZ_i, memZaddr_i, dataZ_i, done_i, clr_i, ready_i,
    input  data_o, valid_o, last_o, idx_o, busy_o, drained_o, ovf_o
  );
endinterface

// File: rtl/conv_result_buffer.sv
// rtl/conv_result_buffer.sv - captures Z-memory writes and streams them out on done
//
// Purpose: stands in for the passive Z RAM. Every in-range write is stored;
// on done_i the captured vector (addresses 0 .. highest written) is streamed
// in address order over a valid/ready interface.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : conv_result_buffer_if.slave (Z-write port, stream, status)

module conv_result_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_result_buffer_if.slave    bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH:0]     r_count;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic                    r_drained;
  logic                    r_ovf;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_in_range;
  logic                    w_wr_ok;
  logic                    w_drop;
  logic [ADDR_WIDTH:0]     w_addr_p1;
  logic                    w_at_last;
  logic                    w_valid;
  logic                    w_last;
  logic                    w_busy;
  logic                    w_xfer;

  assign w_in_range = ({1'b0, bus.memZaddr_i} < DEPTH_C);
  assign w_addr_p1  = {1'b0, bus.memZaddr_i} + CNT_ONE;
  // Writes are only accepted while not draining, so the stream never
  // observes a partially updated vector.
  assign w_wr_ok    = bus.writeZ_i && w_in_range && (r_state != S_DRAIN);
  assign w_drop     = bus.writeZ_i && (!w_in_range || (r_state == S_DRAIN));
  assign w_at_last  = ({1'b0, r_rd_ptr} == (r_count - CNT_ONE));
  assign w_xfer     = w_valid && bus.ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_last       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        // done_i with nothing captured is ignored here.
        if (w_wr_ok) begin
          w_next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (bus.done_i) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_valid = 1'b1;
        w_last  = w_at_last;
        if (bus.ready_i && w_at_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_drained <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_drained <= w_xfer && w_last;

      // A drop in the same cycle as clr_i keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_i) begin
        r_ovf <= 1'b0;
      end

      if (w_xfer && w_last) begin
        r_count <= '0;
      end else if (w_wr_ok && (w_addr_p1 > r_count)) begin
        r_count <= w_addr_p1;
      end

      if (w_xfer) begin
        r_rd_ptr <= w_last ? '0 : (r_rd_ptr + PTR_ONE);
      end else if ((r_state == S_CAPTURE) && bus.done_i) begin
        r_rd_ptr <= '0;
      end
    end
  end

  // Storage is deliberately not reset; entries are only read below r_count.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[bus.memZaddr_i[IW-1:0]] <= bus.dataZ_i;
    end
  end

  assign bus.data_o    = r_mem[r_rd_ptr[IW-1:0]];
  assign bus.valid_o   = w_valid;
  assign bus.last_o    = w_last;
  assign bus.idx_o     = r_rd_ptr;
  assign bus.busy_o    = w_busy;
  assign bus.drained_o = r_drained;
  assign bus.ovf_o     = r_ovf;

endmodule

// File: tb/tb_conv_result_buffer.sv
// tb/tb_conv_result_buffer.sv - directed self-checking bench for conv_result_buffer

module tb_conv_result_buffer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  conv_result_buffer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) zif ();

  conv_result_buffer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(6),
    .DEPTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(zif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    zif.writeZ_i   = 1'b1;
    zif.memZaddr_i = a;
    zif.dataZ_i    = d;
    tick();
    zif.writeZ_i   = 1'b0;
  endtask

  task automatic start_drain();
    zif.done_i = 1'b1;
    tick();
    zif.done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (zif.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", zif.valid_o); end
    n_checks++; if (zif.last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b exp 0", zif.last_o); end
    n_checks++; if (zif.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", zif.busy_o); end
    n_checks++; if (zif.drained_o !== 1'b0) begin n_fail++; $display("FAIL reset_drained got %0b exp 0", zif.drained_o); end
    n_checks++; if (zif.ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", zif.ovf_o); end
    n_checks++; if (zif.idx_o !== 6'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", zif.idx_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp_d;
    for (int i = 0; i < 5; i++) wr(6'(i), 16'((i + 1) * 10));
    n_checks++; if (zif.busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_capture got %0b exp 1", zif.busy_o); end
    n_checks++; if (zif.valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_capture got %0b exp 0", zif.valid_o); end
    zif.ready_i = 1'b1;
    start_drain();
    for (int k = 0; k < 5; k++) begin
      exp_d = 16'((k + 1) * 10);
      n_checks++; if (zif.valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid k=%0d got %0b exp 1", k, zif.valid_o); end
      n_checks++; if (zif.data_o !== exp_d) begin n_fail++; $display("FAIL basic_data k=%0d got %0d exp %0d", k, zif.data_o, exp_d); end
      n_checks++; if (zif.idx_o !== 6'(k)) begin n_fail++; $display("FAIL basic_idx got %0d exp %0d", zif.idx_o, k); end
      n_checks++; if (zif.last_o !== (k == 4)) begin n_fail++; $display("FAIL basic_last k=%0d got %0b", k, zif.last_o); end
      tick();
    end
    n_checks++; if (zif.drained_o !== 1'b1) begin n_fail++; $display("FAIL basic_drained got %0b exp 1", zif.drained_o); end
    n_checks++; if (zif.busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %0b exp 0", zif.busy_o); end
    n_checks++; if (zif.valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after got %0b exp 0", zif.valid_o); end
    tick();
    n_checks++; if (zif.drained_o !== 1'b0) begin n_fail++; $display("FAIL basic_drained_pulse got %0b exp 0", zif.drained_o); end
    zif.ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat;
    logic [15:0] exp_d;
    int n;
    int cyc;
    pat = 4'b1001;
    for (int i = 0; i < 5; i++) wr(6'(i), 16'((i + 1) * 10));
    zif.ready_i = 1'b0;
    start_drain();
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 40) begin
      zif.ready_i = pat[cyc % 4];
      exp_d = 16'((n + 1) * 10);
      n_checks++; if (zif.valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got %0b exp 1", cyc, zif.valid_o); end
      n_checks++; if (zif.idx_o !== 6'(n)) begin n_fail++; $display("FAIL bp_idx cyc=%0d got %0d exp %0d", cyc, zif.idx_o, n); end
      n_checks++; if (zif.data_o !== exp_d) begin n_fail++; $display("FAIL bp_data cyc=%0d got %0d exp %0d", cyc, zif.data_o, exp_d); end
      n_checks++; if (zif.last_o !== (n == 4)) begin n_fail++; $display("FAIL bp_last cyc=%0d got %0b", cyc, zif.last_o); end
      if (zif.ready_i) n++;
      tick();
      cyc++;
    end
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL bp_count got %0d exp 5", n); end
    n_checks++; if (zif.drained_o !== 1'b1) begin n_fail++; $display("FAIL bp_drained got %0b exp 1", zif.drained_o); end
    zif.ready_i = 1'b0;
    tick();
  endtask

  task automatic test_overwrite_done();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h0001; exp_v[1] = 16'h0002; exp_v[2] = 16'hBEEF;
    wr(6'd0, 16'h0001);
    wr(6'd1, 16'h0002);
    wr(6'd2, 16'h0003);
    zif.writeZ_i = 1'b1; zif.memZaddr_i = 6'd2; zif.dataZ_i = 16'hBEEF; zif.done_i = 1'b1;
    tick();
    zif.writeZ_i = 1'b0; zif.done_i = 1'b0;
    zif.ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (zif.valid_o !== 1'b1) begin n_fail++; $display("FAIL ow_valid k=%0d got %0b exp 1", k, zif.valid_o); end
      n_checks++; if (zif.data_o !== exp_v[k]) begin n_fail++; $display("FAIL ow_data k=%0d got %h exp %h", k, zif.data_o, exp_v[k]); end
      n_checks++; if (zif.last_o !== (k == 2)) begin n_fail++; $display("FAIL ow_last k=%0d got %0b", k, zif.last_o); end
      tick();
    end
    n_checks++; if (zif.busy_o !== 1'b0) begin n_fail++; $display("FAIL ow_busy_after got %0b exp 0", zif.busy_o); end
    zif.ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'd5; exp_v[1] = 16'd6; exp_v[2] = 16'd7;
    wr(6'd0, 16'd5);
    wr(6'd1, 16'd6);
    wr(6'd2, 16'd7);
    zif.ready_i = 1'b0;
    start_drain();
    wr(6'd1, 16'hFFFF);
    n_checks++; if (zif.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_write got %0b exp 1", zif.ovf_o); end
    n_checks++; if (zif.idx_o !== 6'd0) begin n_fail++; $display("FAIL ovf_idx_hold got %0d exp 0", zif.idx_o); end
    zif.ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (zif.data_o !== exp_v[k]) begin n_fail++; $display("FAIL ovf_data k=%0d got %h exp %h", k, zif.data_o, exp_v[k]); end
      tick();
    end
    zif.ready_i = 1'b0;
    zif.clr_i = 1'b1;
    tick();
    zif.clr_i = 1'b0;
    n_checks++; if (zif.ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %0b exp 0", zif.ovf_o); end
    wr(6'd63, 16'h1234);
    n_checks++; if (zif.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_addr63 got %0b exp 1", zif.ovf_o); end
    n_checks++; if (zif.busy_o !== 1'b0) begin n_fail++; $display("FAIL ovf_addr63_busy got %0b exp 0", zif.busy_o); end
    zif.clr_i = 1'b1;
    wr(6'd40, 16'h5555);
    zif.clr_i = 1'b0;
    n_checks++; if (zif.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %0b exp 1", zif.ovf_o); end
    zif.clr_i = 1'b1;
    tick();
    zif.clr_i = 1'b0;
    n_checks++; if (zif.ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2 got %0b exp 0", zif.ovf_o); end
    wr(6'd0, 16'd9);
    wr(6'd32, 16'h7777);
    n_checks++; if (zif.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_capture_oob got %0b exp 1", zif.ovf_o); end
    zif.ready_i = 1'b1;
    start_drain();
    n_checks++; if (zif.data_o !== 16'd9) begin n_fail++; $display("FAIL ovf_count_data got %0d exp 9", zif.data_o); end
    n_checks++; if (zif.last_o !== 1'b1) begin n_fail++; $display("FAIL ovf_count_last got %0b exp 1", zif.last_o); end
    tick();
    n_checks++; if (zif.drained_o !== 1'b1) begin n_fail++; $display("FAIL ovf_count_drained got %0b exp 1", zif.drained_o); end
    zif.ready_i = 1'b0;
    zif.clr_i = 1'b1;
    tick();
    zif.clr_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_drain();
    n_checks++; if (zif.valid_o !== 1'b0) begin n_fail++; $display("FAIL empty_done_valid got %0b exp 0", zif.valid_o); end
    n_checks++; if (zif.busy_o !== 1'b0) begin n_fail++; $display("FAIL empty_done_busy got %0b exp 0", zif.busy_o); end
    for (int i = 0; i < 6; i++) wr(6'(i), 16'(200 + i));
    zif.ready_i = 1'b1;
    start_drain();
    tick();
    tick();
    n_checks++; if (zif.idx_o !== 6'd2) begin n_fail++; $display("FAIL mid_idx got %0d exp 2", zif.idx_o); end
    rst = 1'b1;
    #1;
    n_checks++; if (zif.valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %0b exp 0", zif.valid_o); end
    n_checks++; if (zif.busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %0b exp 0", zif.busy_o); end
    n_checks++; if (zif.idx_o !== 6'd0) begin n_fail++; $display("FAIL mid_rst_idx got %0d exp 0", zif.idx_o); end
    tick();
    rst = 1'b0;
    zif.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) wr(6'(i), 16'(100 + i));
    zif.ready_i = 1'b1;
    start_drain();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (zif.valid_o !== 1'b1) begin n_fail++; $display("FAIL post_valid k=%0d got %0b exp 1", k, zif.valid_o); end
      n_checks++; if (zif.data_o !== 16'(100 + k)) begin n_fail++; $display("FAIL post_data k=%0d got %0d exp %0d", k, zif.data_o, 100 + k); end
      n_checks++; if (zif.last_o !== (k == 2)) begin n_fail++; $display("FAIL post_last k=%0d got %0b", k, zif.last_o); end
      tick();
    end
    n_checks++; if (zif.valid_o !== 1'b0) begin n_fail++; $display("FAIL post_valid_end got %0b exp 0", zif.valid_o); end
    n_checks++; if (zif.drained_o !== 1'b1) begin n_fail++; $display("FAIL post_drained got %0b exp 1", zif.drained_o); end
    zif.ready_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    zif.writeZ_i = 1'b0;
    zif.memZaddr_i = '0;
    zif.dataZ_i = '0;
    zif.done_i = 1'b0;
    zif.clr_i = 1'b0;
    zif.ready_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overwrite_done();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
